// File: rtl/gate_sweep_checker.sv
// Exhaustive gate tester: walks every input vector, holds it SETTLE cycles, samples dut_y.
// Define SWEEP_GRAY_EN to walk vectors in reflected Gray order instead of binary.
module gate_sweep_checker #(
  parameter int                    WIDTH  = 3,
  parameter int                    SETTLE = 2,
  parameter logic [2**WIDTH-1:0]   TRUTH  = 8'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] fail_vec,
  output logic             fail_vld
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] idx;
  logic [7:0]       cnt;
  logic             last, settled, mismatch;

  // idx is the sweep position; vec_out is its (optionally Gray-coded) image
`ifdef SWEEP_GRAY_EN
  assign vec_out = idx ^ (idx >> 1);
`else
  assign vec_out = idx;
`endif

  assign last     = (idx == {WIDTH{1'b1}});
  assign settled  = (cnt == 8'(SETTLE - 1));
  // case inequality so x/z from the gate counts as a failure
  assign mismatch = (dut_y !== TRUTH[vec_out]);
  assign busy     = (state == ST_SETTLE) || (state == ST_SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (settled) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
      fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          idx <= '0;
          cnt <= '0;
          if (start) begin
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            pass     <= 1'b0;
          end
        end
        ST_SETTLE: cnt <= settled ? 8'd0 : cnt + 8'd1;
        ST_SAMPLE: begin
          cnt <= '0;
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!fail_vld) begin
              fail_vec <= vec_out;
              fail_vld <= 1'b1;
            end
          end
          if (!last) idx <= idx + 1'b1;
        end
        ST_DONE: begin
          // err_cnt already includes the final sample here
          done <= 1'b1;
          pass <= (err_cnt == '0);
          idx  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 3: number of gate-under-test inputs, legal range 1..6.
REQ-002 SHALL have parameter SETTLE, default 2: clock cycles each vector is held before sampling, legal range 1..255.
REQ-003 SHALL have parameter TRUTH, default 8'h7F, width 2**WIDTH bits: expected output, where TRUTH[v] is the expected output for input vector value v (default = 3-input NAND).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-007 SHALL have port vec_out, output, WIDTH bits: stimulus driven to the gate-under-test inputs (vec_out[0] = first gate input).
REQ-008 SHALL have port dut_y, input, 1 bit: output of the gate-under-test (may be 0, 1, x or z).
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-011 SHALL have port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-012 SHALL have port err_cnt, output, WIDTH+1 bits: mismatch count of the current or last sweep.
REQ-013 SHALL have port fail_vec, output, WIDTH bits: vector value of the first mismatch.
REQ-014 SHALL have port fail_vld, output, 1 bit: fail_vec holds a captured value.

Function
REQ-015 SHALL implement states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 SHALL, in IDLE, go to SETTLE when start=1, with vec_out=first vector, settle counter=0, and err_cnt, fail_vld and pass cleared.
REQ-017 SHALL stay in SETTLE for exactly SETTLE cycles with vec_out stable, then go to SAMPLE.
REQ-018 SHALL, in SAMPLE, compare dut_y against TRUTH[vec_out] using 4-state case equality: x or z on dut_y counts as a mismatch.
REQ-019 SHALL, on a mismatch, increment err_cnt; on the first mismatch only, load fail_vec=vec_out and set fail_vld=1.
REQ-020 SHALL, after a SAMPLE that is not the last vector, advance vec_out to the next vector and return to SETTLE.
REQ-021 SHALL, after the SAMPLE of the last vector, go to DONE.
REQ-022 SHALL, in DONE, assert done=1 for one cycle, set pass=(err_cnt==0 including the final sample), then return to IDLE.
REQ-023 SHALL give each vector SETTLE+1 cycles.
REQ-024 SHALL assert done on the (2**WIDTH)*(SETTLE+1)+1-th rising edge after the edge that sampled start.
REQ-025 SHALL drive busy=1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-026 SHALL ignore start while not in IDLE, including start held high during DONE.
REQ-027 SHALL begin a new sweep on the edge after DONE when start is held high continuously.
REQ-028 SHALL never wrap err_cnt: its maximum value is 2**WIDTH, which fits in WIDTH+1 bits.
REQ-029 SHALL hold vec_out at the last vector in DONE, then return it to 0 in IDLE.
REQ-030 SHALL hold pass, err_cnt, fail_vec and fail_vld after DONE until the next accepted start.

Reset
REQ-031 SHALL, on rst=1 asynchronously and regardless of state, force: state=IDLE; vec_out=0; busy=0; done=0; pass=0; err_cnt=0; fail_vec=0; fail_vld=0; settle counter=0.
REQ-032 SHALL abandon a sweep in progress when reset asserts, without emitting done.
REQ-033 SHALL accept no start while rst=1; the first start can be accepted on the first rising edge after rst deasserts.

Configuration
REQ-034 SHALL, when macro SWEEP_GRAY_EN is defined, sequence vectors in reflected Gray order (WIDTH=3: 0,1,3,2,6,7,5,4), so exactly one gate input toggles per step; the last vector is the Gray code of 2**WIDTH-1.
REQ-035 SHALL, when SWEEP_GRAY_EN is undefined, sequence vectors in binary ascending order 0..2**WIDTH-1.
REQ-036 SHALL index TRUTH by the vector value in both modes; all other behaviour and latency are identical in both modes.

Verification
REQ-037 SHALL cover: defaults with the 3-input NAND switch model on vec_out/dut_y, start pulse -> done on edge 25, pass=1, err_cnt=0, fail_vld=0.
REQ-038 SHALL cover: TRUTH=8'h80 with the NAND model connected -> err_cnt=8, pass=0, fail_vec=0, fail_vld=1.
REQ-039 SHALL cover: dut_y tied to z -> err_cnt=8, pass=0, fail_vec=0.
REQ-040 SHALL cover: rst pulsed while vec_out=3 -> all outputs 0 immediately, no done pulse; a following start gives a full 25-cycle sweep with pass=1.
REQ-041 SHALL cover: start pulsed again at cycle 10 of a sweep -> ignored, done still on edge 25; start held high -> back-to-back sweeps with done 26 cycles apart.
REQ-042 SHALL cover: SWEEP_GRAY_EN defined -> vec_out sequence 0,1,3,2,6,7,5,4 with a single-bit change per step, and pass=1 against the NAND model.
